// File: rtl/if_stage.sv
// Instruction-fetch stage: owns the PC and drives the 1-cycle-latency inst SRAM.
// It hands {pc, inst} to ID and buffers the instruction across ID stalls.
// Optional `IF_ADEF_EXC_EN adds fs_adef and aligns misaligned fetch addresses.
module if_stage #(
  parameter logic [31:0] RESET_PC = 32'h1c00_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ds_allowin,
  input  logic [32:0] br_bus,
  output logic        fs_to_ds_valid,
  output logic [63:0] fs_to_ds_bus,
  output logic        inst_sram_en,
  output logic        inst_sram_we,
  output logic [31:0] inst_sram_addr,
  output logic [31:0] inst_sram_wdata,
  input  logic [31:0] inst_sram_rdata
`ifdef IF_ADEF_EXC_EN
  ,
  output logic        fs_adef
`endif
);

  logic        fs_valid;
  logic [31:0] fs_pc;
  logic [31:0] inst_buf;
  logic        buf_valid;

  logic        br_taken;
  logic [31:0] br_target;
  logic        fs_ready_go;
  logic        fs_allowin;
  logic [31:0] seq_pc;
  logic [31:0] nextpc;
  logic [31:0] fs_inst;
  logic        stall_capture;

  assign br_taken    = br_bus[32];
  assign br_target   = br_bus[31:0];

  assign fs_ready_go = 1'b1;
  assign fs_allowin  = ~fs_valid | (fs_ready_go & ds_allowin);
  assign seq_pc      = fs_pc + 32'd4;
  assign nextpc      = br_taken ? br_target : seq_pc;

  // A taken branch always issues its target, even while ID is stalled.
  assign inst_sram_en    = ~reset & (fs_allowin | br_taken);
  assign inst_sram_we    = 1'b0;
  assign inst_sram_wdata = 32'd0;

  // Capture only when the SRAM output would otherwise be lost; a branch kills it.
  assign stall_capture = fs_valid & ~ds_allowin & ~buf_valid & ~br_taken;

`ifdef IF_ADEF_EXC_EN
  assign fs_adef        = fs_valid & (fs_pc[1:0] != 2'b00);
  assign inst_sram_addr = {nextpc[31:2], 2'b00};
  assign fs_inst        = fs_adef ? 32'd0 : (buf_valid ? inst_buf : inst_sram_rdata);
`else
  assign inst_sram_addr = nextpc;
  assign fs_inst        = buf_valid ? inst_buf : inst_sram_rdata;
`endif

  assign fs_to_ds_valid = fs_valid & fs_ready_go & ~br_taken;
  assign fs_to_ds_bus   = {fs_pc, fs_inst};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fs_valid  <= 1'b0;
      fs_pc     <= RESET_PC - 32'd4;
      inst_buf  <= 32'd0;
      buf_valid <= 1'b0;
    end else if (inst_sram_en) begin
      fs_valid  <= 1'b1;
      fs_pc     <= nextpc;
      buf_valid <= 1'b0;
    end else if (stall_capture) begin
      inst_buf  <= inst_sram_rdata;
      buf_valid <= 1'b1;
    end
  end

endmodule

// File: tb/tb_if_stage.sv
// Directed bench for if_stage; a word-equals-address SRAM model backs the fetch port.
module tb_if_stage;

  logic        clk;
  logic        reset;
  logic        ds_allowin;
  logic [32:0] br_bus;
  logic        fs_to_ds_valid;
  logic [63:0] fs_to_ds_bus;
  logic        inst_sram_en;
  logic        inst_sram_we;
  logic [31:0] inst_sram_addr;
  logic [31:0] inst_sram_wdata;
  logic [31:0] inst_sram_rdata;
`ifdef IF_ADEF_EXC_EN
  logic        fs_adef;
`endif

  logic [31:0] sram_q;
  logic        override;
  int          errors;
  int          checks;

  if_stage dut (
    .clk             (clk),
    .reset           (reset),
    .ds_allowin      (ds_allowin),
    .br_bus          (br_bus),
    .fs_to_ds_valid  (fs_to_ds_valid),
    .fs_to_ds_bus    (fs_to_ds_bus),
    .inst_sram_en    (inst_sram_en),
    .inst_sram_we    (inst_sram_we),
    .inst_sram_addr  (inst_sram_addr),
    .inst_sram_wdata (inst_sram_wdata),
    .inst_sram_rdata (inst_sram_rdata)
`ifdef IF_ADEF_EXC_EN
    ,
    .fs_adef         (fs_adef)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous SRAM: each word holds its own address.
  always @(posedge clk) begin
    if (inst_sram_en) sram_q <= inst_sram_addr;
  end
  assign inst_sram_rdata = override ? 32'hDEAD_BEEF : sram_q;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    errors     = 0;
    checks     = 0;
    override   = 1'b0;
    sram_q     = 32'd0;
    reset      = 1'b1;
    ds_allowin = 1'b1;
    br_bus     = 33'd0;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_valid", 64'(fs_to_ds_valid), 64'd0);
    check("rst_en",    64'(inst_sram_en),   64'd0);
    check("tie_we",    64'(inst_sram_we),   64'd0);
    check("tie_wdata", 64'(inst_sram_wdata), 64'd0);
    reset = 1'b0;
    #1;
    check("first_en",   64'(inst_sram_en),   64'd1);
    check("first_addr", 64'(inst_sram_addr), 64'h1c00_0000);

    // Streaming, one per cycle
    tick();
    check("s0_valid", 64'(fs_to_ds_valid), 64'd1);
    check("s0_bus",   fs_to_ds_bus, {32'h1c00_0000, 32'h1c00_0000});
    check("s0_addr",  64'(inst_sram_addr), 64'h1c00_0004);
    tick();
    check("s1_bus",   fs_to_ds_bus, {32'h1c00_0004, 32'h1c00_0004});
    tick();
    check("s2_bus",   fs_to_ds_bus, {32'h1c00_0008, 32'h1c00_0008});

    // Stall for five cycles at 0x1c000008
    ds_allowin = 1'b0;
    #1;
    check("st0_en",  64'(inst_sram_en), 64'd0);
    check("st0_bus", fs_to_ds_bus, {32'h1c00_0008, 32'h1c00_0008});
    for (int i = 1; i < 5; i++) begin
      tick();
      override = 1'b1;
      #1;
      check("st_en",    64'(inst_sram_en),   64'd0);
      check("st_valid", 64'(fs_to_ds_valid), 64'd1);
      check("st_bus",   fs_to_ds_bus, {32'h1c00_0008, 32'h1c00_0008});
    end
    ds_allowin = 1'b1;
    #1;
    check("rel_valid", 64'(fs_to_ds_valid), 64'd1);
    check("rel_bus",   fs_to_ds_bus, {32'h1c00_0008, 32'h1c00_0008});
    check("rel_addr",  64'(inst_sram_addr), 64'h1c00_000c);
    override = 1'b0;
    tick();
    check("rel_next", fs_to_ds_bus, {32'h1c00_000c, 32'h1c00_000c});

    // Branch redirect with IF at 0x1c000010
    tick();
    check("pre_br_bus", fs_to_ds_bus, {32'h1c00_0010, 32'h1c00_0010});
    br_bus = {1'b1, 32'h1c00_0100};
    #1;
    check("br_valid", 64'(fs_to_ds_valid), 64'd0);
    check("br_en",    64'(inst_sram_en),   64'd1);
    check("br_addr",  64'(inst_sram_addr), 64'h1c00_0100);
    tick();
    br_bus = 33'd0;
    #1;
    check("br_tgt_valid", 64'(fs_to_ds_valid), 64'd1);
    check("br_tgt_bus",   fs_to_ds_bus, {32'h1c00_0100, 32'h1c00_0100});

    // Branch while stalled with a buffered instruction
    ds_allowin = 1'b0;
    tick();
    br_bus = {1'b1, 32'h1c00_0200};
    #1;
    check("bbr_valid", 64'(fs_to_ds_valid), 64'd0);
    check("bbr_en",    64'(inst_sram_en),   64'd1);
    check("bbr_addr",  64'(inst_sram_addr), 64'h1c00_0200);
    tick();
    br_bus   = 33'd0;
    override = 1'b1;
    #1;
    check("bbr_nobuf", fs_to_ds_bus, {32'h1c00_0200, 32'hDEAD_BEEF});
    override = 1'b0;
    #1;
    check("bbr_bus", fs_to_ds_bus, {32'h1c00_0200, 32'h1c00_0200});
    check("bbr_en2", 64'(inst_sram_en), 64'd0);
    ds_allowin = 1'b1;
    tick();
    check("post_bbr", fs_to_ds_bus, {32'h1c00_0204, 32'h1c00_0204});

    // Asynchronous reset between edges
    #3;
    reset = 1'b1;
    #1;
    check("arst_valid", 64'(fs_to_ds_valid), 64'd0);
    check("arst_en",    64'(inst_sram_en),   64'd0);
    check("arst_pc",    64'(fs_to_ds_bus[63:32]), 64'h1bff_fffc);
    tick();
    reset = 1'b0;
    #1;
    check("arst_addr", 64'(inst_sram_addr), 64'h1c00_0000);
    tick();
    check("arst_bus", fs_to_ds_bus, {32'h1c00_0000, 32'h1c00_0000});

    // PC wrap at the top of the address space
    br_bus = {1'b1, 32'hFFFF_FFFC};
    tick();
    br_bus = 33'd0;
    #1;
    check("wrap_bus",  fs_to_ds_bus, {32'hFFFF_FFFC, 32'hFFFF_FFFC});
    check("wrap_addr", 64'(inst_sram_addr), 64'h0);
    tick();
    check("wrap_zero", fs_to_ds_bus, {32'h0, 32'h0});

    // Misaligned branch target
    br_bus = {1'b1, 32'h1c00_0102};
    #1;
`ifdef IF_ADEF_EXC_EN
    check("mis_addr", 64'(inst_sram_addr), 64'h1c00_0100);
    check("mis_en",   64'(inst_sram_en),   64'd1);
    tick();
    br_bus = 33'd0;
    #1;
    check("mis_adef", 64'(fs_adef), 64'd1);
    check("mis_bus",  fs_to_ds_bus, {32'h1c00_0102, 32'h0});
    check("mis_next", 64'(inst_sram_addr), 64'h1c00_0104);
`else
    check("mis_addr", 64'(inst_sram_addr), 64'h1c00_0102);
    check("mis_en",   64'(inst_sram_en),   64'd1);
    tick();
    br_bus = 33'd0;
    #1;
    check("mis_bus",  fs_to_ds_bus, {32'h1c00_0102, 32'h1c00_0102});
    check("mis_next", 64'(inst_sram_addr), 64'h1c00_0106);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
